step_dir_generator: RTL and testbench
=====================================

Name: step_dir_generator

Overview:
- Transmit end of the step/direction interface consumed by the team's 2-bit up/down step counter.
- Accepts a signed target position and a step period, and emits clean step pulses plus a direction level until the tracked position equals the target.
- Outputs drive the counter's step clock and UpDown inputs; phase_out mirrors what that counter should display.

Parameters:
POS_W, 8, width of signed position/target (two's complement)
DIV_W, 8, width of step-period field in clk cycles
PULSE_W, 2, step high time in clk cycles (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-low reset; 0 clears all state immediately
start  input  1  1-cycle request; honoured only in IDLE
target  input  POS_W  signed destination position, latched on accepted start
period  input  DIV_W  clk cycles per step, latched on accepted start
abort  input  1  stop motion at the next safe point
step_out  output  1  step pulse to counter's step clock input
up_down  output  1  direction; 0 = count up (position+1), 1 = count down (counter's UpDown encoding)
busy  output  1  high from accepted start until return to IDLE
done  output  1  1-cycle pulse: target reached (not on abort)
position  output  POS_W  signed tracked position
phase_out  output  2  position[1:0]; equals downstream counter output

Behaviour:
- Reset (reset=0, async): state IDLE, step_out=0, up_down=0, busy=0, done=0, position=0, phase_out=0; a pulse in progress is truncated.
- Period clamp: eff_period = max(period, PULSE_W+1), latched with target.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE: start=1 latches target and eff_period.
  - If target==position: go to DONE, with no step.
  - Otherwise go to SETUP, busy=1, up_down = (target<position) using signed compare.
- SETUP: 1 cycle, step_out=0, up_down stable. Guarantees 1 cycle of direction setup before the step edge. Next state is HIGH.
- HIGH: step_out=1 for PULSE_W cycles.
  - position is updated (+1 if up_down=0, else -1) on the clock edge entering HIGH, so position changes in the same cycle step_out rises.
- LOW: step_out=0 for eff_period-PULSE_W cycles. On exit:
  - position==target: go to DONE.
  - Otherwise: go to HIGH (direction unchanged; target is fixed for the move).
- DONE: done=1 for one cycle, busy=0 in this cycle, then IDLE.
- Step rate: consecutive step_out rising edges are exactly eff_period cycles apart. First rise is 2 cycles after the start cycle.
- up_down changes only in IDLE→SETUP; never while step_out=1 or in LOW.
- abort:
  - In SETUP or LOW: go to IDLE next cycle, done=0.
  - In HIGH: finish the full PULSE_W pulse, then IDLE; pulses are never shortened.
  - In IDLE or DONE: ignored.
  - abort and start together in IDLE: start wins.
- start while busy: ignored; latched target and period are unchanged.
- No wrap: a move always travels the signed difference directly, so position never crosses ±2^(POS_W-1) for in-range targets.
- phase_out wraps naturally mod 4 (3→0 going up, 0→3 going down).

Decomposition:
- Shared package step_pkg holds:
  - state enum (IDLE, SETUP, HIGH, LOW, DONE);
  - direction constants DIR_UP=1'b0, DIR_DOWN=1'b1.
- The step counter reuses DIR_UP/DIR_DOWN from step_pkg.
- One sub-module, step_timer: loadable DIV_W down-counter.
  - Inputs: load value, enable.
  - Output: 1-cycle expire pulse.
  - Times the HIGH and LOW phases.

Test Plan:
- Reset mid-pulse: drop reset during HIGH → all outputs 0 in the same cycle (asynchronous); after release, IDLE and position=0.
- Up move: position 0, start with target=3, period=4, PULSE_W=2 → 3 pulses, each 2 high/2 low, rises 4 cycles apart; up_down=0 throughout; phase_out 1,2,3; done pulses once with position=3.
- Down move with wrap: from 3, target=-2 (0xFE), period=1 → clamped to 3-cycle spacing; 5 pulses with up_down=1; phase_out 2,1,0,3,2; done with position=-2.
- Zero move: start with target equal to position → no step_out, done 1 cycle after start, busy low.
- Abort: abort asserted in the first pulse's HIGH cycle → pulse completes full PULSE_W, then IDLE, no done, position=±1.
- Busy start: second start mid-move with a different target → ignored; original target reached.
- Abort with start in IDLE: assert both in the same cycle → start accepted.
- Lockstep scoreboard: instantiate the 2-bit counter on step_out/up_down (counter sampling synchronised to clk) → counter output == phase_out after every step.

Source files
------------

// File: rtl/step_pkg.sv
// step_pkg: shared state encoding and direction constants for the step/direction link
package step_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter that flags the last cycle of a timed phase
module step_timer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // reload takes priority; count down while enabled and park at zero
    always_comb cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - DIV_W'(1) : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign expire = en && cnt_q == DIV_W'(1);
endmodule

// File: rtl/step_dir_generator.sv
// step_dir_generator: emits step pulses and a direction level until position reaches target
module step_dir_generator
    import step_pkg::*;
#(
    parameter int POS_W   = 8,
    parameter int DIV_W   = 8,
    parameter int PULSE_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [POS_W-1:0] target,
    input  logic        [DIV_W-1:0] period,
    input  logic                    abort,
    output logic                    step_out,
    output logic                    up_down,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position,
    output logic        [1:0]       phase_out
);
    localparam logic [DIV_W-1:0] PW    = DIV_W'(PULSE_W);
    localparam logic [DIV_W-1:0] MIN_P = DIV_W'(PULSE_W + 1);

    state_t                  state_q, state_d;
    logic signed [POS_W-1:0] tgt_q, tgt_d, pos_q, pos_d;
    logic        [DIV_W-1:0] per_q, per_d, tmr_val;
    logic                    dir_q, dir_d, abort_q, abort_d;
    logic                    step_q, step_d, busy_q, busy_d, done_q, done_d;
    logic                    accept, tmr_load, tmr_en, tmr_expire;

    assign accept   = state_q == IDLE && start;
    assign tmr_load = state_d != state_q;
    assign tmr_en   = state_q == HIGH || state_q == LOW;
    assign tmr_val  = (state_d == HIGH) ? PW : per_q - PW;

    step_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // state register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;

    // next state: a started pulse always runs to completion, abort only cuts SETUP or LOW
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (target == pos_q) ? DONE : SETUP;
            SETUP:   state_d = abort ? IDLE : HIGH;
            HIGH:    if (tmr_expire) state_d = (abort || abort_q) ? IDLE : LOW;
            LOW:     if (abort) state_d = IDLE;
                     else if (tmr_expire) state_d = (pos_q == tgt_q) ? DONE : HIGH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // move parameters, direction and position; position steps on entry to HIGH
    always_comb begin
        tgt_d   = accept ? target : tgt_q;
        per_d   = accept ? ((period < MIN_P) ? MIN_P : period) : per_q;
        dir_d   = (accept && target != pos_q) ? ((target < pos_q) ? DIR_DOWN : DIR_UP) : dir_q;
        abort_d = (state_q == HIGH) && (abort_q || abort);
        pos_d   = (state_d == HIGH && state_q != HIGH) ?
                  ((dir_q == DIR_DOWN) ? pos_q - POS_W'(1) : pos_q + POS_W'(1)) : pos_q;
    end

    // outputs decoded from the next state so they leave a flop glitch-free
    always_comb begin
        step_d = state_d == HIGH;
        busy_d = state_d inside {SETUP, HIGH, LOW};
        done_d = state_d == DONE;
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            tgt_q   <= '0;
            per_q   <= '0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            abort_q <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            per_q   <= per_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            abort_q <= abort_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end

    assign step_out  = step_q;
    assign up_down   = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign position  = pos_q;
    assign phase_out = pos_q[1:0];
endmodule

// File: tb/tb_step_dir_generator.sv
// tb_step_dir_generator: randomized and directed checks against a move-timing reference model
module tb_step_dir_generator;
    import step_pkg::*;

    localparam int PW = 2;

    logic              clk = 0, reset = 0, start = 0, abort = 0;
    logic signed [7:0] target = '0;
    logic        [7:0] period = '0;
    logic              step_out, up_down, busy, done;
    logic signed [7:0] position;
    logic        [1:0] phase_out;

    step_dir_generator #(.POS_W(8), .DIV_W(8), .PULSE_W(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .target    (target),
        .period    (period),
        .abort     (abort),
        .step_out  (step_out),
        .up_down   (up_down),
        .busy      (busy),
        .done      (done),
        .position  (position),
        .phase_out (phase_out)
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0, cyc = 0;
    bit   mv = 0, wd = 0;
    int   s, p0, e, sg, fin_k, steps, bpos = 0;
    logic mdir = DIR_UP;
    logic [1:0] ctr = 2'd0;
    logic step_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, $signed(got), $signed(exp), cyc);
        end
    endtask

    function automatic int cur_pos();
        return mv ? p0 + sg * steps : bpos;
    endfunction

    function automatic bit m_idle();
        return !mv || (cyc - s) >= (wd ? fin_k + 1 : fin_k);
    endfunction

    // advance one clock and compare every output against the move timeline
    task automatic tick();
        int k, e_pos;
        logic e_step, e_busy, e_done;
        @(posedge clk);
        #1;
        cyc++;
        e_step = 0; e_busy = 0; e_done = 0; e_pos = bpos;
        if (mv) begin
            k = cyc - s;
            if (k < fin_k) begin
                e_busy = 1;
                e_step = k >= 2 && (k - 2) % e < PW;
                e_pos  = (k < 2) ? p0 : p0 + sg * ((k - 2) / e + 1);
            end else begin
                e_pos  = p0 + sg * steps;
                e_done = wd && k == fin_k;
            end
        end
        chk("step_out", step_out, e_step);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("position", position, e_pos);
        chk("phase_out", phase_out, e_pos & 3);
        chk("up_down", up_down, mdir);
        if (step_out && !step_prev) begin
            ctr = ctr + ((up_down == DIR_UP) ? 2'd1 : 2'd3);
            chk("lockstep", phase_out, ctr);
        end
        step_prev = step_out;
    endtask

    // drive one start (optionally with abort) and update the model if it is accepted
    task automatic go(input int tgt, input int per, input bit with_abort);
        int p;
        target = tgt[7:0];
        period = per[7:0];
        start  = 1;
        abort  = with_abort;
        if (m_idle()) begin
            p     = cur_pos();
            bpos  = p;
            s     = cyc;
            p0    = p;
            e     = (per < PW + 1) ? PW + 1 : per;
            sg    = (tgt < p) ? -1 : 1;
            steps = (tgt < p) ? p - tgt : tgt - p;
            fin_k = (steps == 0) ? 1 : 2 + steps * e;
            wd    = 1;
            if (steps != 0) mdir = (tgt < p) ? DIR_DOWN : DIR_UP;
            mv    = 1;
        end
        tick();
        start = 0;
        abort = 0;
    endtask

    // one-cycle abort; a started pulse still completes
    task automatic ab();
        int k, j;
        abort = 1;
        k = cyc - s;
        if (mv && k >= 1 && k < fin_k) begin
            wd = 0;
            if (k == 1) begin
                fin_k = 2; steps = 0;
            end else begin
                j = (k - 2) / e;
                steps = j + 1;
                fin_k = ((k - 2) % e < PW) ? 2 + j * e + PW : k + 1;
            end
        end
        tick();
        abort = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_idle() && n < 1000) begin tick(); n++; end
        if (n >= 1000) chk("idle_timeout", 0, 1);
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_step", step_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pos", position, 0);
        reset = 1;
        tick();

        go(3, 4, 0);            wait_idle();
        go(-2, 1, 0);           wait_idle();
        go(-2, 9, 0);           wait_idle();
        go(10, 5, 0); tick();   ab(); wait_idle();
        go(2, 3, 0);  repeat (4) tick(); go(50, 2, 0); wait_idle();
        go(0, 2, 1);            wait_idle();

        for (int i = 0; i < 30; i++) begin
            int t = cur_pos() + int'($urandom_range(0, 12)) - 6;
            bit aborted = 0;
            if (t > 127) t = 127;
            if (t < -128) t = -128;
            go(t, $urandom_range(0, 6), $urandom_range(0, 3) == 0);
            for (int n = 0; n < 400 && !m_idle(); n++) begin
                if (!aborted && $urandom_range(0, 20) == 0) begin ab(); aborted = 1; end
                else if ($urandom_range(0, 12) == 0) go($urandom_range(0, 255) - 128, 3, 0);
                else tick();
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        go(cur_pos() + 4, 6, 0);
        tick();
        tick();
        #2;
        reset = 0;
        #1;
        chk("arst_step", step_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pos", position, 0);
        chk("arst_phase", phase_out, 0);
        chk("arst_dir", up_down, 0);
        mv = 0; bpos = 0; mdir = DIR_UP; ctr = 2'd0; step_prev = 1'b0;
        @(posedge clk);
        #1;
        reset = 1;
        repeat (2) tick();
        go(-3, 3, 0);           wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
